gate_array_pipe: RTL and testbench
==================================

GATE_ARRAY_PIPE -- requirements
Module: gate_array_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result bit width, legal range 1..64.
REQ-002 SHALL have parameter CNT_W, default 16: width of the transaction counter, legal range 2..32.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert and active-low.
REQ-005 SHALL have port a, input, WIDTH: operand A.
REQ-006 SHALL have port b, input, WIDTH: operand B.
REQ-007 SHALL have port op, input, 3: operation select, encoding per REQ-014.
REQ-008 SHALL have port in_valid, input, 1: the input beat (a, b, op) is valid.
REQ-009 SHALL have port in_ready, output, 1: the block can accept an input beat.
REQ-010 SHALL have port y, output, WIDTH: registered bitwise result.
REQ-011 SHALL have ports y_any and y_all, output, 1 each: registered OR-reduction and AND-reduction of y.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-013 SHALL have ports cnt_clr (input, 1), txn_cnt (output, CNT_W) and op_err (output, 1): counter clear, completed-transaction count and sticky illegal-op flag.

Function
REQ-014 SHALL decode op as: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a (b ignored), 7 illegal (y = 0).
REQ-015 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-016 SHALL perform an input transfer when in_valid && in_ready, capturing y, y_any and y_all on that clock edge; latency 1 cycle.
REQ-017 SHALL set out_valid on the edge after an input transfer.
REQ-018 SHALL clear out_valid on an edge where out_valid && out_ready && no input transfer occurs.
REQ-019 SHALL load the new result and keep out_valid=1 on an edge with simultaneous output handshake and input transfer, giving full throughput of 1 beat/cycle.
REQ-020 SHALL hold y, y_any and y_all stable while out_valid && !out_ready.
REQ-021 SHALL make y_any and y_all reflect the same captured y; for WIDTH=1 both equal y.
REQ-022 SHALL increment txn_cnt by 1 on each output handshake (out_valid && out_ready).
REQ-023 SHALL saturate txn_cnt at 2^CNT_W-1 with no wrap.
REQ-024 SHALL apply cnt_clr synchronously, setting txn_cnt to 0; cnt_clr wins over a simultaneous increment.
REQ-025 SHALL set op_err on an input transfer with op=7.
REQ-026 SHALL hold op_err set until reset or cnt_clr; on a cnt_clr coinciding with an op=7 transfer, op_err ends at 1.
REQ-027 SHALL ignore op=7 when in_valid=0 or in_ready=0 (no transfer).

Reset
REQ-028 SHALL, while rst_n=0, force out_valid=0, y=0, y_any=0, y_all=0, txn_cnt=0 and op_err=0 immediately, independent of clk.
REQ-029 SHALL, while in reset, drive in_ready=1 by REQ-015.
REQ-030 SHALL discard any in-flight output on reset assertion mid-operation, without counting it.
REQ-031 SHALL accept a transfer from the first rising edge after rst_n deasserts.

Structure
REQ-032 SHALL place the op encodings (OP_AND..OP_ILL) as named constants in the shared package gate_pkg.
REQ-033 SHALL implement the bitwise function as combinational sub-module gate_bitwise (a, b, op -> y), parametrised by WIDTH.
REQ-034 SHALL keep in gate_array_pipe only the output register, handshake, counter and error flag.

Verification
REQ-035 SHALL verify truth table, WIDTH=8: a=8'hF0, b=8'hCC, op 0..6 with out_ready=1 -> y = C0, FC, 3F, 03, 3C, C3, 0F one cycle after each transfer; y_any=1 for all; y_all=0 for all.
REQ-036 SHALL verify backpressure: transfer a=8'hFF, b=8'hFF, op=0, then hold out_ready=0 for 3 cycles -> in_ready=0, y=8'hFF and y_all=1 held; txn_cnt unchanged until out_ready=1.
REQ-037 SHALL verify throughput: 4 back-to-back beats with out_ready=1 -> out_valid continuously 1 for 4 cycles; txn_cnt=4.
REQ-038 SHALL verify saturation with CNT_W=2: 5 output handshakes -> txn_cnt=3; cnt_clr coinciding with a handshake -> txn_cnt=0.
REQ-039 SHALL verify illegal op: transfer with op=7 -> y=0 and op_err=1; op_err stays 1 after later legal beats; cnt_clr -> op_err=0.
REQ-040 SHALL verify reset mid-operation: rst_n=0 while out_valid=1 and out_ready=0 -> out_valid, y, txn_cnt and op_err reach 0 before the next clk edge.

Source files
------------

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared op encodings for the gate array pipeline
package gate_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_NAND = 3'd2;
    localparam op_t OP_NOR  = 3'd3;
    localparam op_t OP_XOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_NOT  = 3'd6;
    localparam op_t OP_ILL  = 3'd7;

    function automatic logic is_illegal(input op_t op);
        return op == OP_ILL;
    endfunction

endpackage

// File: rtl/gate_bitwise.sv
// rtl/gate_bitwise.sv - combinational bitwise function selected by op
module gate_bitwise
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    // Pure decode of op; the illegal code yields all zeros.
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_ILL:  y = '0;
        endcase
    end

endmodule

// File: rtl/gate_array_pipe.sv
// rtl/gate_array_pipe.sv - registered bitwise stage with handshake, counter and error flag
module gate_array_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_any,
    output logic             y_all,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] txn_cnt,
    output logic             op_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] y_next;
    logic             in_xfer;
    logic             out_xfer;

    gate_bitwise #(
        .WIDTH(WIDTH)
    ) u_bitwise (
        .a  (a),
        .b  (b),
        .op (op),
        .y  (y_next)
    );

    // The single output slot frees up whenever it is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Output register: load on an input transfer, otherwise drop valid once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_any     <= 1'b0;
            y_all     <= 1'b0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            y         <= y_next;
            y_any     <= |y_next;
            y_all     <= &y_next;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of completed output handshakes; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_cnt <= '0;
        end else if (cnt_clr) begin
            txn_cnt <= '0;
        end else if (out_xfer && (txn_cnt != CNT_MAX)) begin
            txn_cnt <= txn_cnt + CNT_ONE;
        end
    end

    // Sticky illegal-op flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_err <= 1'b0;
        end else if (in_xfer && is_illegal(op)) begin
            op_err <= 1'b1;
        end else if (cnt_clr) begin
            op_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gate_array_pipe.sv
// tb/tb_gate_array_pipe.sv - self-checking bench for gate_array_pipe
module tb_gate_array_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [2:0] op = 3'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       cnt_clr = 1'b0;

    logic        in_ready, y_any, y_all, out_valid, op_err;
    logic [7:0]  y;
    logic [15:0] txn_cnt;
    logic        in_ready2, y_any2, y_all2, out_valid2, op_err2;
    logic [7:0]  y2;
    logic [1:0]  txn_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_array_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .y(y), .y_any(y_any), .y_all(y_all),
        .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
        .txn_cnt(txn_cnt), .op_err(op_err)
    );

    gate_array_pipe #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
        .in_valid(in_valid), .in_ready(in_ready2), .y(y2), .y_any(y_any2), .y_all(y_all2),
        .out_valid(out_valid2), .out_ready(out_ready), .cnt_clr(cnt_clr),
        .txn_cnt(txn_cnt2), .op_err(op_err2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: one result slot, saturating handshake counts, sticky error.
    logic       m_valid = 1'b0;
    logic [7:0] m_y = 8'h00;
    logic       m_err = 1'b0;
    int         m_cnt = 0;
    int         m_cnt2 = 0;

    function automatic logic [7:0] ref_gate(input logic [7:0] x, input logic [7:0] z, input logic [2:0] o);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return ~(x & z);
            3'd3: return ~(x | z);
            3'd4: return x ^ z;
            3'd5: return ~(x ^ z);
            3'd6: return ~x;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_y     <= 8'h00;
            m_err   <= 1'b0;
            m_cnt   <= 0;
            m_cnt2  <= 0;
        end else begin
            if (in_valid && (!m_valid || out_ready)) begin
                m_valid <= 1'b1;
                m_y     <= ref_gate(a, b, op);
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
            if (cnt_clr) begin
                m_cnt  <= 0;
                m_cnt2 <= 0;
            end else if (m_valid && out_ready) begin
                m_cnt  <= (m_cnt  >= 65535) ? 65535 : m_cnt + 1;
                m_cnt2 <= (m_cnt2 >= 3)     ? 3     : m_cnt2 + 1;
            end
            if (in_valid && (!m_valid || out_ready) && op == 3'd7)
                m_err <= 1'b1;
            else if (cnt_clr)
                m_err <= 1'b0;
        end
    end

    // Every cycle, shortly before the falling edge, compare both instances to the model.
    always @(posedge clk) begin
        #4;
        chk("m_out_valid", out_valid, m_valid);
        chk("m_y", y, m_y);
        chk("m_y_any", y_any, m_y != 8'h00);
        chk("m_y_all", y_all, m_y == 8'hFF);
        chk("m_in_ready", in_ready, !m_valid || out_ready);
        chk("m_txn_cnt", txn_cnt, m_cnt);
        chk("m_op_err", op_err, m_err);
        chk("m_out_valid2", out_valid2, m_valid);
        chk("m_y2", y2, m_y);
        chk("m_txn_cnt2", txn_cnt2, m_cnt2);
        chk("m_op_err2", op_err2, m_err);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    logic [7:0] tt [7] = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F};

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_y", y, 8'h00);
        chk("rst_txn_cnt", txn_cnt, 16'd0);
        chk("rst_op_err", op_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        step();
        step();
        rst_n = 1'b1;

        // Truth table, one beat per op.
        for (int i = 0; i < 7; i++) begin
            a = 8'hF0; b = 8'hCC; op = 3'(i); in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk("tt_y", y, tt[i]);
            chk("tt_y_any", y_any, 1'b1);
            chk("tt_y_all", y_all, 1'b0);
            chk("tt_out_valid", out_valid, 1'b1);
        end
        step();
        step();
        chk("tt_txn_cnt", txn_cnt, 16'd7);
        chk("sat_txn_cnt", txn_cnt2, 2'd3);

        // Backpressure holds the result and the counter.
        out_ready = 1'b0; a = 8'hFF; b = 8'hFF; op = 3'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_y", y, 8'hFF);
            chk("bp_y_all", y_all, 1'b1);
            chk("bp_txn_cnt", txn_cnt, 16'd7);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_txn_after", txn_cnt, 16'd8);
        chk("bp_valid_after", out_valid, 1'b0);

        // Clear coinciding with a handshake leaves zero.
        a = 8'h01; b = 8'h01; op = 3'd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_hs_txn", txn_cnt, 16'd0);
        chk("clr_hs_txn2", txn_cnt2, 2'd0);

        // Four back-to-back beats.
        for (int i = 0; i < 4; i++) begin
            a = 8'(i * 17); b = 8'h5A; op = 3'd4; in_valid = 1'b1;
            step();
            chk("thru_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        step();
        chk("thru_txn_cnt", txn_cnt, 16'd4);
        chk("thru_txn_cnt2", txn_cnt2, 2'd3);
        chk("thru_drained", out_valid, 1'b0);

        // Illegal op without a transfer is ignored.
        op = 3'd7; in_valid = 1'b0;
        step();
        chk("ill_novalid", op_err, 1'b0);
        out_ready = 1'b0; a = 8'h0F; b = 8'hF0; op = 3'd1; in_valid = 1'b1;
        step();
        op = 3'd7;
        step();
        chk("ill_notready", op_err, 1'b0);
        chk("ill_held_y", y, 8'hFF);
        in_valid = 1'b0; out_ready = 1'b1;
        step();

        // Illegal transfer sets a sticky flag.
        a = 8'hFF; b = 8'hFF; op = 3'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ill_y", y, 8'h00);
        chk("ill_err", op_err, 1'b1);
        chk("ill_y_any", y_any, 1'b0);
        a = 8'hFF; b = 8'h0F; op = 3'd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("ill_legal_y", y, 8'hF0);
        chk("ill_sticky", op_err, 1'b1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("ill_cleared", op_err, 1'b0);
        cnt_clr = 1'b1; op = 3'd7; in_valid = 1'b1;
        step();
        cnt_clr = 1'b0; in_valid = 1'b0;
        chk("ill_clr_race", op_err, 1'b1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;

        // Reset while a result is stalled.
        a = 8'hAA; b = 8'h55; op = 3'd7; in_valid = 1'b1;
        step();
        op = 3'd1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        chk("mid_pre_valid", out_valid, 1'b1);
        chk("mid_pre_err", op_err, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", out_valid, 1'b0);
        chk("mid_y", y, 8'h00);
        chk("mid_txn_cnt", txn_cnt, 16'd0);
        chk("mid_op_err", op_err, 1'b0);
        chk("mid_y_all", y_all, 1'b0);
        step();
        rst_n = 1'b1; a = 8'h03; b = 8'h05; op = 3'd4; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1'b1);
        chk("post_rst_y", y, 8'h06);
        chk("post_rst_txn", txn_cnt, 16'd0);
        step();
        chk("post_rst_txn1", txn_cnt, 16'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
